link_monitor: RTL and testbench

LINK_MONITOR -- requirements
Module: link_monitor

---
 rtl/link_monitor_pkg.sv | 14 +
 rtl/link_monitor_sync_bit.sv | 21 ++
 rtl/link_monitor.sv | 103 ++++++++++
 tb/tb_link_monitor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/link_monitor_pkg.sv
// Shared link-state encodings for link_monitor and the PCS/management blocks that decode link_state.
package link_monitor_pkg;

  typedef enum logic [1:0] {
    LM_FAIL = 2'd0,
    LM_WAIT = 2'd1,
    LM_UP   = 2'd2
  } lm_state_e;

  function automatic logic rx_idle(input logic [1:0] rx_valid);
    return rx_valid == 2'b00;
  endfunction

endpackage

// File: rtl/link_monitor_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset.
module sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/link_monitor.sv
// Link bring-up/monitor FSM: FAIL -> WAIT (stable qualification) -> UP, with idle and signal-loss detection.
// Optional LINK_MONITOR_STATS_EN adds a saturating link_drops counter of UP->FAIL transitions.
module link_monitor
  import link_monitor_pkg::*;
#(
  parameter logic [15:0] STABLE_CYCLES = 16'd41250,
  parameter logic [7:0]  IDLE_TIMEOUT  = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_detect,
  input  logic [1:0] rx_valid,
  input  logic       rx_err,
  output logic       dp_rst,
  output logic       link_status,
  output logic [1:0] link_state
`ifdef LINK_MONITOR_STATS_EN
  ,
  output logic [15:0] link_drops
`endif
);

  localparam int unsigned SW = $bits(STABLE_CYCLES);
  localparam int unsigned IW = $bits(IDLE_TIMEOUT);

  logic          sd_s;
  logic          idle_cyc;
  lm_state_e     state_q, state_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [IW-1:0] idle_q, idle_d;

  sync_bit u_sd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (signal_detect),
    .q     (sd_s)
  );

  assign idle_cyc = rx_idle(rx_valid);

  // Checks are ordered by priority: signal loss, idle timeout, rx_err clear, stable completion.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    idle_d   = idle_q;
    case (state_q)
      LM_FAIL: begin
        if (sd_s) state_d = LM_WAIT;
      end
      LM_WAIT, LM_UP: begin
        idle_d = idle_cyc ? idle_q + 1'b1 : '0;
        if (!sd_s) begin
          state_d = LM_FAIL;
        end else if (idle_cyc && (idle_q == IDLE_TIMEOUT - 1'b1)) begin
          state_d = LM_FAIL;
        end else if (state_q == LM_WAIT) begin
          if (rx_err) begin
            stable_d = '0;
          end else if (stable_q == STABLE_CYCLES - 1'b1) begin
            state_d = LM_UP;
          end else if (stable_q != '1) begin
            stable_d = stable_q + 1'b1;
          end
        end
      end
      default: state_d = LM_FAIL;
    endcase
    if (state_d != state_q) begin
      stable_d = '0;
      idle_d   = '0;
    end
  end

  // Outputs are registered from next-state so they track the state register without lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LM_FAIL;
      stable_q    <= '0;
      idle_q      <= '0;
      dp_rst      <= 1'b1;
      link_status <= 1'b0;
      link_state  <= LM_FAIL;
    end else begin
      state_q     <= state_d;
      stable_q    <= stable_d;
      idle_q      <= idle_d;
      dp_rst      <= (state_d == LM_FAIL);
      link_status <= (state_d == LM_UP);
      link_state  <= state_d;
    end
  end

`ifdef LINK_MONITOR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_drops <= '0;
    end else if ((state_q == LM_UP) && (state_d == LM_FAIL) && (link_drops != 16'hFFFF)) begin
      link_drops <= link_drops + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_link_monitor.sv
// Directed table-driven bench for link_monitor with STABLE_CYCLES=8, IDLE_TIMEOUT=4.
module tb_link_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       signal_detect;
  logic [1:0] rx_valid;
  logic       rx_err;
  logic       dp_rst;
  logic       link_status;
  logic [1:0] link_state;
`ifdef LINK_MONITOR_STATS_EN
  logic [15:0] link_drops;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned exp_drops = 0;

  localparam logic [1:0] F = 2'd0;
  localparam logic [1:0] W = 2'd1;
  localparam logic [1:0] U = 2'd2;

  link_monitor #(
    .STABLE_CYCLES (16'd8),
    .IDLE_TIMEOUT  (8'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signal_detect (signal_detect),
    .rx_valid      (rx_valid),
    .rx_err        (rx_err),
    .dp_rst        (dp_rst),
    .link_status   (link_status),
    .link_state    (link_state)
`ifdef LINK_MONITOR_STATS_EN
    ,
    .link_drops    (link_drops)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [1:0]  rv;
    logic        err;
    int unsigned reps;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [3:0] outs_for(input logic [1:0] st);
    return {st == F, st == U, st};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, sample #1 after the rising edge.
  task automatic step(input logic sd, input logic [1:0] rv, input logic err,
                      input logic [1:0] st, input string name);
    signal_detect = sd;
    rx_valid      = rv;
    rx_err        = err;
    @(posedge clk);
    #1;
    check(name, {28'd0, dp_rst, link_status, link_state}, {28'd0, outs_for(st)});
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] prev_st;

    tbl[0]  = '{1'b1, 2'b11, 1'b0, 2, F};
    tbl[1]  = '{1'b1, 2'b11, 1'b0, 8, W};
    tbl[2]  = '{1'b1, 2'b11, 1'b0, 2, U};
    tbl[3]  = '{1'b1, 2'b11, 1'b1, 1, U};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 3, U};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 1, F};
    tbl[6]  = '{1'b1, 2'b11, 1'b0, 1, W};
    tbl[7]  = '{1'b1, 2'b11, 1'b0, 7, W};
    tbl[8]  = '{1'b1, 2'b11, 1'b1, 1, W};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, 7, W};
    tbl[10] = '{1'b1, 2'b11, 1'b0, 1, U};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 2, U};
    tbl[12] = '{1'b0, 2'b11, 1'b0, 1, F};
    tbl[13] = '{1'b0, 2'b11, 1'b0, 3, F};
    tbl[14] = '{1'b1, 2'b11, 1'b0, 2, F};
    tbl[15] = '{1'b1, 2'b11, 1'b0, 1, W};
    tbl[16] = '{1'b1, 2'b11, 1'b0, 5, W};
    tbl[17] = '{1'b0, 2'b11, 1'b0, 2, W};
    tbl[18] = '{1'b0, 2'b11, 1'b0, 1, F};
    tbl[19] = '{1'b1, 2'b11, 1'b0, 2, F};
    tbl[20] = '{1'b1, 2'b11, 1'b0, 1, W};
    tbl[21] = '{1'b1, 2'b00, 1'b0, 2, W};
    tbl[22] = '{1'b1, 2'b10, 1'b0, 1, W};
    tbl[23] = '{1'b1, 2'b00, 1'b0, 3, W};
    tbl[24] = '{1'b1, 2'b00, 1'b0, 1, F};
    tbl[25] = '{1'b1, 2'b11, 1'b0, 8, W};
    tbl[26] = '{1'b1, 2'b11, 1'b0, 2, U};

    rst_n         = 1'b0;
    signal_detect = 1'b1;
    rx_valid      = 2'b11;
    rx_err        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {28'd0, dp_rst, link_status, link_state}, {28'd0, outs_for(F)});
`ifdef LINK_MONITOR_STATS_EN
    check("reset_drops", {16'd0, link_drops}, 32'd0);
`endif

    rst_n   = 1'b1;
    prev_st = F;
    for (int i = 0; i < 27; i++) begin
      for (int unsigned r = 0; r < tbl[i].reps; r++) begin
        step(tbl[i].sd, tbl[i].rv, tbl[i].err, tbl[i].st, $sformatf("row%0d_cyc%0d", i, r));
        if (prev_st == U && tbl[i].st == F) exp_drops++;
        prev_st = tbl[i].st;
      end
`ifdef LINK_MONITOR_STATS_EN
      check($sformatf("row%0d_drops", i), {16'd0, link_drops}, exp_drops);
`endif
    end

    // Link is UP here; reset must take effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {28'd0, dp_rst, link_status, link_state}, {28'd0, outs_for(F)});
`ifdef LINK_MONITOR_STATS_EN
    check("async_reset_drops", {16'd0, link_drops}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b11, 1'b0, F, "restart_c1");
    step(1'b1, 2'b11, 1'b0, F, "restart_c2");
    step(1'b1, 2'b11, 1'b0, W, "restart_c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
